// File: rtl/surf_event_collector.sv
// surf_event_collector
// Builds one framed byte stream per event from seven per-SURF AXI4S byte
// streams, all in the sysclk domain.
// Frame layout: MAGIC, count[15:8], count[7:0], {0,evt_mask},
//   then each enabled SURF's payload in ascending order, then {0,missing}
//   with tlast set.
// A SURF whose tvalid stays low for TIMEOUT cycles while it is being streamed
// is abandoned. Its bit is set in the trailer, and timeout_o pulses.
// Ports:
//   sysclk_i, rst_i          clock, async active-high reset
//   enable_i, surf_mask_i    event start control (sampled in IDLE only)
//   s_sK_t{data,valid,ready,last}  per-SURF input streams, K = 0..6
//   m_evt_t{data,valid,ready,last} framed output stream
//   event_count_o            completed frames (wraps)
//   busy_o                   not IDLE
//   timeout_o                one-cycle pulse when a SURF is abandoned
module surf_event_collector #(
  parameter int         TIMEOUT = 1024,
  parameter logic [7:0] MAGIC   = 8'hA5
) (
  input  logic        sysclk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic [6:0]  surf_mask_i,
  input  logic [7:0]  s_s0_tdata, s_s1_tdata, s_s2_tdata, s_s3_tdata,
  input  logic [7:0]  s_s4_tdata, s_s5_tdata, s_s6_tdata,
  input  logic        s_s0_tvalid, s_s1_tvalid, s_s2_tvalid, s_s3_tvalid,
  input  logic        s_s4_tvalid, s_s5_tvalid, s_s6_tvalid,
  output logic        s_s0_tready, s_s1_tready, s_s2_tready, s_s3_tready,
  output logic        s_s4_tready, s_s5_tready, s_s6_tready,
  input  logic        s_s0_tlast, s_s1_tlast, s_s2_tlast, s_s3_tlast,
  input  logic        s_s4_tlast, s_s5_tlast, s_s6_tlast,
  output logic [7:0]  m_evt_tdata,
  output logic        m_evt_tvalid,
  input  logic        m_evt_tready,
  output logic        m_evt_tlast,
  output logic [15:0] event_count_o,
  output logic        busy_o,
  output logic        timeout_o
);
  localparam int          NUM_LANES = 7;
  localparam logic [15:0] TO_LAST   = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, HDR, SEL, STREAM, TRL} state_t;

  logic [NUM_LANES-1:0][7:0] s_tdata;
  logic [NUM_LANES-1:0]      s_tvalid, s_tlast, s_tready;

  assign s_tdata  = {s_s6_tdata, s_s5_tdata, s_s4_tdata, s_s3_tdata,
                     s_s2_tdata, s_s1_tdata, s_s0_tdata};
  assign s_tvalid = {s_s6_tvalid, s_s5_tvalid, s_s4_tvalid, s_s3_tvalid,
                     s_s2_tvalid, s_s1_tvalid, s_s0_tvalid};
  assign s_tlast  = {s_s6_tlast, s_s5_tlast, s_s4_tlast, s_s3_tlast,
                     s_s2_tlast, s_s1_tlast, s_s0_tlast};
  assign {s_s6_tready, s_s5_tready, s_s4_tready, s_s3_tready,
          s_s2_tready, s_s1_tready, s_s0_tready} = s_tready;

  state_t               state, state_nxt;
  logic [NUM_LANES-1:0] rem_mask, evt_mask, missing;
  logic [1:0]           hdr_idx;
  logic [2:0]           cur, sel_k;
  logic [15:0]          to_cnt;
  logic [7:0]           beat_q;     // registered header/trailer byte

  logic start, out_hs, cur_vld, cur_last, timeout_hit;

  assign start       = enable_i && |(surf_mask_i & s_tvalid);
  assign out_hs      = m_evt_tvalid && m_evt_tready;
  assign cur_vld     = s_tvalid[cur];
  assign cur_last    = s_tlast[cur];
  assign timeout_hit = (state == STREAM) && !cur_vld && (to_cnt == TO_LAST);
  assign busy_o      = (state != IDLE);

  // Lowest remaining SURF wins.
  always_comb begin
    sel_k = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--)
      if (rem_mask[i]) sel_k = 3'(i);
  end

  // Only the SURF currently being streamed sees tready; every other lane
  // (including disabled ones) keeps its data queued upstream.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign s_tready[g] = (state == STREAM) && (cur == 3'(g)) && m_evt_tready;
  end

  always_comb begin
    state_nxt    = state;
    m_evt_tdata  = beat_q;
    m_evt_tvalid = 1'b0;
    m_evt_tlast  = 1'b0;
    timeout_o    = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = HDR;
      HDR: begin
        m_evt_tvalid = 1'b1;
        if (out_hs && hdr_idx == 2'd3) state_nxt = SEL;
      end
      SEL: state_nxt = (|rem_mask) ? STREAM : TRL;
      STREAM: begin
        m_evt_tdata  = s_tdata[cur];
        m_evt_tvalid = cur_vld;
        if (cur_vld && m_evt_tready && cur_last) begin
          state_nxt = SEL;
        end else if (timeout_hit) begin
          timeout_o = 1'b1;
          state_nxt = SEL;
        end
      end
      TRL: begin
        m_evt_tvalid = 1'b1;
        m_evt_tlast  = 1'b1;
        if (out_hs) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sysclk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= IDLE;
      rem_mask      <= '0;
      evt_mask      <= '0;
      missing       <= '0;
      hdr_idx       <= '0;
      cur           <= '0;
      to_cnt        <= '0;
      beat_q        <= '0;
      event_count_o <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (start) begin
          rem_mask <= surf_mask_i;
          evt_mask <= surf_mask_i;
          missing  <= '0;
          hdr_idx  <= '0;
          beat_q   <= MAGIC;
        end
        HDR: if (out_hs) begin
          hdr_idx <= hdr_idx + 2'd1;
          case (hdr_idx)
            2'd0:    beat_q <= event_count_o[15:8];
            2'd1:    beat_q <= event_count_o[7:0];
            2'd2:    beat_q <= {1'b0, evt_mask};
            default: beat_q <= beat_q;
          endcase
        end
        SEL: begin
          if (|rem_mask) begin
            cur             <= sel_k;
            rem_mask[sel_k] <= 1'b0;
            to_cnt          <= '0;
          end else begin
            // missing is final here; the last STREAM cycle has committed.
            beat_q <= {1'b0, missing};
          end
        end
        STREAM: begin
          // Only idle source cycles count; backpressure with data pending
          // is the consumer's problem, not a dead SURF.
          to_cnt <= cur_vld ? 16'd0 : to_cnt + 16'd1;
          if (timeout_hit) missing[cur] <= 1'b1;
        end
        TRL: if (out_hs) event_count_o <= event_count_o + 16'd1;
        default: ;
      endcase
    end
  end
endmodule
